// File: rtl/pcie_phy_pkg.sv
// Shared logical-PHY definitions: link rate encoding and 128b/130b block constants.
package pcie_phy_pkg;

    typedef enum logic [2:0] {
        RATE_GEN1 = 3'd0,
        RATE_GEN2 = 3'd1,
        RATE_GEN3 = 3'd2,
        RATE_GEN4 = 3'd3,
        RATE_GEN5 = 3'd4
    } rate_speed_e;

    // One 128b/130b block carries 16 symbols per lane.
    localparam int SYMBOLS_PER_BLOCK = 16;
    localparam int BLK_CNT_W         = $clog2(SYMBOLS_PER_BLOCK);

    localparam logic [1:0] SYNC_HDR_DATA = 2'b10;
    localparam logic [1:0] SYNC_HDR_OS   = 2'b01;

    // Gen3 and above use 128b/130b framing.
    function automatic logic is_gen3_plus(rate_speed_e rate);
        return (rate >= RATE_GEN3);
    endfunction

    // Last PIPE word index inside a block for a given per-lane width in bytes.
    function automatic logic [BLK_CNT_W-1:0] block_last_count(logic [2:0] width_bytes);
        logic [BLK_CNT_W-1:0] last;
        case (width_bytes)
            3'd1:    last = BLK_CNT_W'(SYMBOLS_PER_BLOCK - 1);
            3'd2:    last = BLK_CNT_W'(SYMBOLS_PER_BLOCK / 2 - 1);
            3'd4:    last = BLK_CNT_W'(SYMBOLS_PER_BLOCK / 4 - 1);
            default: last = '0;
        endcase
        return last;
    endfunction

endpackage

// File: rtl/tx_block_counter.sv
// Counts PIPE words inside a 128b/130b block and flags the first word of each block.
// A clear forces the current word to be treated as a block start.
module tx_block_counter
    import pcie_phy_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 accept_i,
    input  logic [2:0]           width_i,
    input  logic                 clear_i,
    output logic                 block_start_o,
    output logic [BLK_CNT_W-1:0] count_o
);

    logic [BLK_CNT_W-1:0] count_q;
    logic [BLK_CNT_W-1:0] count_d;
    logic [BLK_CNT_W-1:0] count_eff;
    logic [BLK_CNT_W-1:0] last_cnt;

    // Next count: wrap at the last word of the block, advance only on accepted beats.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        last_cnt  = block_last_count(width_i);
        count_eff = clear_i ? '0 : count_q;
        count_d   = count_eff;
        // >= rather than == so a width shrink mid-block can never run past the wrap point.
        if (accept_i) begin
            count_d = (count_eff >= last_cnt) ? '0 : count_eff + 1'b1;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst_i) count_q <= '0;
        else       count_q <= count_d;
    end

    assign block_start_o = (count_eff == '0);
    assign count_o       = count_q;

endmodule

// File: rtl/tx_byte_striping.sv
// Transmit byte striping: maps the lane-striped symbol stream onto per-lane PIPE TxData,
// applying lane reversal, PIPE byte ordering and Gen3+ block framing.
// Optional build macro TX_STRIPE_SKID_EN adds a one-entry skid buffer with registered ready.
module tx_byte_striping
    import pcie_phy_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int MAX_NUM_LANES = 4
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic                                    phy_link_up_i,
    input  logic                                    lane_reverse_i,
    input  rate_speed_e                             curr_data_rate_i,
    input  logic [5:0]                              pipe_width_i,
    input  logic [5:0]                              num_active_lanes_i,
    input  logic [MAX_NUM_LANES*DATA_WIDTH-1:0]     data_i,
    input  logic [(DATA_WIDTH/8)*MAX_NUM_LANES-1:0] data_k_i,
    input  logic                                    data_valid_i,
    input  logic [1:0]                              sync_header_i,
    output logic                                    data_ready_o,
    input  logic                                    phy_ready_i,
    output logic [MAX_NUM_LANES*DATA_WIDTH-1:0]     data_o,
    output logic [(DATA_WIDTH/8)*MAX_NUM_LANES-1:0] data_k_o,
    output logic [MAX_NUM_LANES-1:0]                data_valid_o,
    output logic [2*MAX_NUM_LANES-1:0]              sync_header_o,
    output logic [MAX_NUM_LANES-1:0]                start_block_o
);

    localparam int BPL = DATA_WIDTH / 8;

    typedef struct packed {
        logic [MAX_NUM_LANES*DATA_WIDTH-1:0] data;
        logic [BPL*MAX_NUM_LANES-1:0]        k;
        logic [MAX_NUM_LANES-1:0]            valid;
        logic [2*MAX_NUM_LANES-1:0]          sync;
        logic [MAX_NUM_LANES-1:0]            start;
    } out_word_t;

    logic                 gen3;
    logic [2:0]           width_bytes;
    logic                 width_legal;
    logic                 lanes_legal;
    logic                 cfg_legal;
    logic                 cfg_changed;
    logic                 accept;
    logic                 out_valid;
    logic                 block_start;
    logic [BLK_CNT_W-1:0] blk_count;
    logic                 cnt_accept;
    logic                 cnt_clear;
    out_word_t            map_word;
    out_word_t            out_q;
    out_word_t            out_d;
    rate_speed_e          rate_q;
    rate_speed_e          rate_d;
    logic [5:0]           lanes_q;
    logic [5:0]           lanes_d;
    logic [5:0]           width_q;
    logic [5:0]           width_d;
    int                   n_lanes;
    int                   w_bytes;
    int                   src;
    int                   phys;
    int                   dst;

    // Decode the active configuration and detect changes against last cycle's value.
    always_comb begin
        gen3        = is_gen3_plus(curr_data_rate_i);
        width_bytes = 3'd0;
        case (pipe_width_i)
            6'd8:    width_bytes = 3'd1;
            6'd16:   width_bytes = 3'd2;
            6'd32:   width_bytes = 3'd4;
            default: width_bytes = 3'd0;
        endcase
        width_legal = (width_bytes != 3'd0) && (int'(width_bytes) * 8 <= DATA_WIDTH);
        lanes_legal = (num_active_lanes_i != 6'd0)
                   && ((num_active_lanes_i & (num_active_lanes_i - 6'd1)) == 6'd0)
                   && (int'(num_active_lanes_i) <= MAX_NUM_LANES);
        cfg_legal   = width_legal && lanes_legal;
        rate_d      = curr_data_rate_i;
        lanes_d     = num_active_lanes_i;
        width_d     = pipe_width_i;
        // A width change is treated like a rate or lane change: the block restarts.
        cfg_changed = (curr_data_rate_i != rate_q) || (num_active_lanes_i != lanes_q)
                   || (pipe_width_i != width_q);
        cnt_accept  = accept && gen3 && cfg_legal;
        cnt_clear   = !phy_link_up_i || !gen3 || !cfg_legal
                   || (cfg_changed && (blk_count != '0));
    end

    tx_block_counter u_block_counter (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .accept_i      (cnt_accept),
        .width_i       (width_bytes),
        .clear_i       (cnt_clear),
        .block_start_o (block_start),
        .count_o       (blk_count)
    );

    // Byte striping: slot s of logical lane L lands in PIPE byte W-1-s of its physical lane.
    always_comb begin
        map_word = '0;
        n_lanes  = int'(num_active_lanes_i);
        w_bytes  = int'(width_bytes);
        src      = 0;
        phys     = 0;
        dst      = 0;
        if (cfg_legal) begin
            for (int l = 0; l < MAX_NUM_LANES; l++) begin
                for (int s = 0; s < BPL; s++) begin
                    if (l < n_lanes && s < w_bytes) begin
                        src  = s * n_lanes + l;
                        phys = lane_reverse_i ? (n_lanes - 1 - l) : l;
                        dst  = phys * BPL + (w_bytes - 1 - s);
                        map_word.data[dst*8 +: 8] = data_i[src*8 +: 8];
                        map_word.k[dst]           = data_k_i[src];
                    end
                end
                // Active lanes form the same set 0..N-1 with or without reversal.
                if (l < n_lanes) begin
                    map_word.valid[l] = 1'b1;
                    if (gen3 && block_start) begin
                        map_word.sync[2*l +: 2] = sync_header_i;
                        map_word.start[l]       = 1'b1;
                    end
                end
            end
        end
    end

    assign out_valid = |out_q.valid;

`ifdef TX_STRIPE_SKID_EN
    out_word_t skid_q;
    out_word_t skid_d;
    logic      skid_full_q;
    logic      skid_full_d;
    logic      ready_q;
    logic      ready_d;

    // Output stage fed from the skid entry first, then directly from the input.
    always_comb begin
        accept      = data_valid_i && ready_q;
        out_d       = out_q;
        skid_d      = skid_q;
        skid_full_d = skid_full_q;
        if (!phy_link_up_i) begin
            out_d       = '0;
            skid_full_d = 1'b0;
        end else if (!out_valid || phy_ready_i) begin
            if (skid_full_q) begin
                out_d       = skid_q;
                skid_full_d = 1'b0;
            end else if (accept) begin
                out_d = map_word;
            end else if (phy_ready_i) begin
                out_d.valid = '0;
            end
        end else if (accept) begin
            skid_d      = map_word;
            skid_full_d = 1'b1;
        end
        ready_d = phy_link_up_i && !skid_full_d;
    end

    // Skid entry and registered ready.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            skid_q      <= '0;
            skid_full_q <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            skid_q      <= skid_d;
            skid_full_q <= skid_full_d;
            ready_q     <= ready_d;
        end
    end

    assign data_ready_o = ready_q;
`else
    // Output register loads on accept and drops valid once the PIPE side takes the word.
    always_comb begin
        data_ready_o = !rst_i && phy_link_up_i && (!out_valid || phy_ready_i);
        accept       = data_valid_i && data_ready_o;
        out_d        = out_q;
        if (!phy_link_up_i) begin
            out_d = '0;
        end else if (accept) begin
            out_d = map_word;
        end else if (phy_ready_i) begin
            out_d.valid = '0;
        end
    end
`endif

    // Output and configuration-tracking registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_q   <= '0;
            rate_q  <= RATE_GEN1;
            lanes_q <= '0;
            width_q <= '0;
        end else begin
            out_q   <= out_d;
            rate_q  <= rate_d;
            lanes_q <= lanes_d;
            width_q <= width_d;
        end
    end

    assign data_o        = out_q.data;
    assign data_k_o      = out_q.k;
    assign data_valid_o  = out_q.valid;
    assign sync_header_o = out_q.sync;
    assign start_block_o = out_q.start;

endmodule

// File: tb/tb_tx_byte_striping.sv
// Directed self-checking bench for tx_byte_striping (default parameters: 32-bit, 4 lanes).
module tb_tx_byte_striping;
    import pcie_phy_pkg::*;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         phy_link_up_i;
    logic         lane_reverse_i;
    rate_speed_e  curr_data_rate_i;
    logic [5:0]   pipe_width_i;
    logic [5:0]   num_active_lanes_i;
    logic [127:0] data_i;
    logic [15:0]  data_k_i;
    logic         data_valid_i;
    logic [1:0]   sync_header_i;
    logic         data_ready_o;
    logic         phy_ready_i;
    logic [127:0] data_o;
    logic [15:0]  data_k_o;
    logic [3:0]   data_valid_o;
    logic [7:0]   sync_header_o;
    logic [3:0]   start_block_o;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] PAT16  = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    localparam logic [127:0] EXP_W4 = 128'h03070B0F_02060A0E_0105090D_0004080C;

    tx_byte_striping #(.DATA_WIDTH(32), .MAX_NUM_LANES(4)) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .phy_link_up_i      (phy_link_up_i),
        .lane_reverse_i     (lane_reverse_i),
        .curr_data_rate_i   (curr_data_rate_i),
        .pipe_width_i       (pipe_width_i),
        .num_active_lanes_i (num_active_lanes_i),
        .data_i             (data_i),
        .data_k_i           (data_k_i),
        .data_valid_i       (data_valid_i),
        .sync_header_i      (sync_header_i),
        .data_ready_o       (data_ready_o),
        .phy_ready_i        (phy_ready_i),
        .data_o             (data_o),
        .data_k_o           (data_k_o),
        .data_valid_o       (data_valid_o),
        .sync_header_o      (sync_header_o),
        .start_block_o      (start_block_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        int sent;
        int rcv;

        rst_i              = 1'b1;
        phy_link_up_i      = 1'b1;
        lane_reverse_i     = 1'b0;
        curr_data_rate_i   = RATE_GEN1;
        pipe_width_i       = 6'd8;
        num_active_lanes_i = 6'd4;
        data_i             = '0;
        data_k_i           = '0;
        data_valid_i       = 1'b1;
        sync_header_i      = 2'b00;
        phy_ready_i        = 1'b1;

        // Reset state
        step();
        step();
        check("rst_ready", data_ready_o, 0);
        check("rst_valid", data_valid_o, 0);
        check("rst_data",  data_o, 0);
        check("rst_sync",  sync_header_o, 0);
        check("rst_start", start_block_o, 0);
        rst_i        = 1'b0;
        data_valid_i = 1'b0;
        step();

        // 1. Gen1, W=1, N=4, straight mapping
        data_i       = 128'h03020100;
        data_valid_i = 1'b1;
        #1;
        check("t1_ready", data_ready_o, 1);
        step();
        check("t1_data",  data_o, 128'h00000003_00000002_00000001_00000000);
        check("t1_valid", data_valid_o, 4'hF);
        check("t1_sync",  sync_header_o, 0);
        check("t1_start", start_block_o, 0);

        // 2. Lane reversal with a K byte on input byte 1
        lane_reverse_i = 1'b1;
        data_k_i       = 16'h0002;
        step();
        check("t2_data", data_o, 128'h00000000_00000001_00000002_00000003);
        check("t2_k",    data_k_o, 16'h0100);
        data_valid_i   = 1'b0;
        lane_reverse_i = 1'b0;
        data_k_i       = '0;
        step();
        check("t2_drain", data_valid_o, 0);

        // 3. Gen3, W=2, N=2: 8-word blocks
        curr_data_rate_i   = RATE_GEN3;
        pipe_width_i       = 6'd16;
        num_active_lanes_i = 6'd2;
        sync_header_i      = SYNC_HDR_DATA;
        data_i             = 128'hDDCCBBAA;
        step();
        data_valid_i = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step();
            if (i == 0) begin
                check("t3_data",  data_o, 128'h00000000_00000000_0000BBDD_0000AACC);
                check("t3_valid", data_valid_o, 4'h3);
            end
            check($sformatf("t3_start%0d", i), start_block_o, (i % 8 == 0) ? 4'h3 : 4'h0);
            check($sformatf("t3_sync%0d", i), sync_header_o, (i % 8 == 0) ? 8'h0A : 8'h00);
        end
        data_valid_i = 1'b0;
        step();

        // 4. Gen3, W=4, N=4 with a 3-cycle PIPE stall mid-block (config change restarts the block)
        pipe_width_i       = 6'd32;
        num_active_lanes_i = 6'd4;
        sync_header_i      = SYNC_HDR_OS;
        data_i             = PAT16;
        step();
        data_valid_i = 1'b1;
        step();
        check("t4_b0_data",  data_o, EXP_W4);
        check("t4_b0_start", start_block_o, 4'hF);
        check("t4_b0_sync",  sync_header_o, 8'h55);
        step();
        check("t4_b1_start", start_block_o, 4'h0);
        phy_ready_i = 1'b0;
        data_i      = {4{32'hFFFF_FFFF}};
        #1;
        check("t4_stall_ready", data_ready_o, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("t4_hold_data%0d", i), data_o, EXP_W4);
            check($sformatf("t4_hold_valid%0d", i), data_valid_o, 4'hF);
            check($sformatf("t4_hold_ready%0d", i), data_ready_o, 0);
        end
        phy_ready_i = 1'b1;
        data_i      = PAT16;
        for (int b = 2; b <= 4; b++) begin
            step();
            check($sformatf("t4_b%0d_start", b), start_block_o, (b == 4) ? 4'hF : 4'h0);
        end

        // 5. Link down at count 2 of 4, block restarts after link up
        step();
        check("t5_b5_start", start_block_o, 4'h0);
        phy_link_up_i = 1'b0;
        #1;
        check("t5_down_ready", data_ready_o, 0);
        step();
        check("t5_down_valid", data_valid_o, 0);
        phy_link_up_i = 1'b1;
        step();
        check("t5_up_valid", data_valid_o, 4'hF);
        check("t5_up_start", start_block_o, 4'hF);
        data_valid_i = 1'b0;
        step();

        // 6a. Illegal N=3: beats accepted and dropped
        curr_data_rate_i   = RATE_GEN1;
        pipe_width_i       = 6'd8;
        num_active_lanes_i = 6'd3;
        data_valid_i       = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("t6_ready%0d", i), data_ready_o, 1);
            step();
            check($sformatf("t6_valid%0d", i), data_valid_o, 0);
        end

        // 6b. 10 beats with a one-cycle PIPE ready drop: every beat arrives, in order
        num_active_lanes_i = 6'd4;
        data_valid_i       = 1'b0;
        step();
        sent = 0;
        rcv  = 0;
        for (int cyc = 0; cyc < 60 && rcv < 10; cyc++) begin
            phy_ready_i  = (cyc != 3);
            data_valid_i = (sent < 10);
            data_i       = 128'(sent);
            #1;
            if (data_valid_o[0] && phy_ready_i) begin
                check($sformatf("t6_seq%0d", rcv), data_o[7:0], 8'(rcv));
                rcv++;
            end
            if (data_valid_i && data_ready_o) sent++;
            step();
        end
        check("t6_count", rcv, 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
